// File: rtl/instr_fetch.sv
// Instruction fetch unit: fetches one word per instruction, holds it for execute,
// and resolves branches, jumps and halt at the end of the execute cycle.
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] IN,
    output logic        valid,
    input  logic        J,
    input  logic [1:0]  B,
    input  logic        offset_sel,
    input  logic [15:0] im_offset,
    input  logic [15:0] reg_target,
    input  logic        Z,
    input  logic        stall,
    output logic [15:0] pc,
    output logic        halted,
    output logic [15:0] icount
);

    typedef enum logic [1:0] {
        FETCH,
        EXEC,
        HALT
    } state_t;

    state_t      state, state_nx;
    logic        started;
    logic        retire;
    logic        is_halt;
    logic        taken;
    logic [15:0] target;
    logic [15:0] pc_nx;

    // started keeps the request low until the first edge after reset is released
    assign imem_req  = (state == FETCH) && started;
    assign imem_addr = pc;
    assign valid     = (state == EXEC);
    assign halted    = (state == HALT);

    always_comb begin
        state_nx = state;
        retire   = (state == EXEC) && !stall;
        is_halt  = (IN[31:27] == 5'b11111);
        taken    = J & (((B == 2'd0) & Z) | ((B == 2'd1) & ~Z) | B[1]);
        target   = offset_sel ? reg_target : (pc + im_offset);
        pc_nx    = taken ? target : (pc + 16'd1);
        case (state)
            FETCH: if (imem_req && imem_ack) state_nx = EXEC;
            EXEC:  if (retire) state_nx = is_halt ? HALT : FETCH;
            HALT:  state_nx = HALT;
            default: state_nx = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            started <= 1'b0;
            pc      <= RESET_PC;
            IN      <= '0;
            icount  <= '0;
        end else begin
            state   <= state_nx;
            started <= 1'b1;
            if ((state == FETCH) && imem_req && imem_ack)
                IN <= imem_data;
            if (retire) begin
                icount <= icount + 16'd1;
                if (!is_halt)
                    pc <= pc_nx;
            end
        end
    end

endmodule
